fir_multimode_mac: RTL and testbench

//  Parametrised, runtime-selectable FIR filter: one datapath serving four modes
//  (0=LP, 1=HP, 2=BP, 3=MA), each with its own programmable coefficient bank.

---
 rtl/fir_multimode_mac.sv | 121 ++++++++++++
 tb/tb_fir_multimode_mac.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_multimode_mac.sv
// rtl/fir_multimode_mac.sv - four-mode FIR filter sharing one time-multiplexed MAC
// One tap per cycle into a full-precision accumulator, then round-half-up and saturate.
module fir_multimode_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [1:0]               mode,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sat,
  input  logic                     coef_we,
  input  logic [1:0]               coef_bank,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS);
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam logic [AW-1:0]           LAST_IDX = AW'(TAPS - 1);
  localparam logic signed [COEF_W-1:0] MA_COEF = COEF_W'((1 << (COEF_W - 1)) / TAPS);
  localparam logic signed [ACC_W-1:0]  HALF    = ACC_W'(1) << (COEF_W - 2);
  localparam logic signed [ACC_W-1:0]  SMAX    = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0]  SMIN    = -(ACC_W'(1) << (DATA_W - 1));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state, state_n;
  logic signed [DATA_W-1:0]  taps [TAPS];
  logic signed [COEF_W-1:0]  coef [4][TAPS];
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   rsum;
  logic signed [ACC_W-1:0]   rnd;
  logic signed [PW-1:0]      prod;
  logic [AW-1:0]             idx;
  logic [1:0]                mode_l;
  logic                      accept;

  assign prod = PW'(taps[idx]) * PW'(coef[mode_l][idx]);
  assign rsum = acc + HALF;
  assign rnd  = rsum >>> (COEF_W - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_n = MAC;
        end
      end
      MAC:     if (idx == LAST_IDX) state_n = OUT;
      OUT:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bank 3 resets to a unity-gain moving average so the block filters without setup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) taps[k] <= '0;
      for (int b = 0; b < 4; b++)
        for (int k = 0; k < TAPS; k++)
          coef[b][k] <= (b == 3) ? MA_COEF : '0;
      acc       <= '0;
      idx       <= '0;
      mode_l    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      coef_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      coef_err  <= 1'b0;
      if (coef_we) begin
        if (state == IDLE) coef[coef_bank][coef_addr] <= coef_data;
        else               coef_err <= 1'b1;
      end
      if (accept) begin
        taps[0] <= in_data;
        for (int k = 1; k < TAPS; k++) taps[k] <= taps[k-1];
        mode_l <= mode;
        acc    <= '0;
        idx    <= '0;
      end
      if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        idx <= idx + 1'b1;
      end
      if (state == OUT) begin
        out_valid <= 1'b1;
        if (rnd > SMAX) begin
          out_data <= SMAX[DATA_W-1:0];
          out_sat  <= 1'b1;
        end else if (rnd < SMIN) begin
          out_data <= SMIN[DATA_W-1:0];
          out_sat  <= 1'b1;
        end else begin
          out_data <= rnd[DATA_W-1:0];
          out_sat  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_multimode_mac.sv
// tb/tb_fir_multimode_mac.sv - directed checks of fir_multimode_mac at default parameters
module tb_fir_multimode_mac;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_data = '0;
  logic [1:0]         mode = '0;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_sat;
  logic               coef_we = 1'b0;
  logic [1:0]         coef_bank = '0;
  logic [2:0]         coef_addr = '0;
  logic signed [15:0] coef_data = '0;
  logic               coef_err;

  int checks = 0;
  int errors = 0;

  fir_multimode_mac #(.DATA_W(16), .COEF_W(16), .TAPS(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .mode(mode),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat),
    .coef_we(coef_we), .coef_bank(coef_bank), .coef_addr(coef_addr),
    .coef_data(coef_data), .coef_err(coef_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_out(output int res, output int sat, output int lat);
    int n;
    n = 0; res = 0; sat = 0; lat = -1;
    while (n < 20 && lat < 0) begin
      @(negedge clk);
      n++;
      if (out_valid) begin
        res = int'(out_data);
        sat = int'(out_sat);
        lat = n - 1;
      end
    end
    if (lat < 0) check("out_timeout", 0, 1);
  endtask

  task automatic send(input logic signed [15:0] d, input logic [1:0] m,
                      input logic we, input logic [1:0] wb, input logic [2:0] wa,
                      input logic signed [15:0] wd,
                      output int res, output int sat, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    in_valid = 1'b1; in_data = d; mode = m;
    coef_we = we; coef_bank = wb; coef_addr = wa; coef_data = wd;
    @(posedge clk);
    #1;
    in_valid = 1'b0; coef_we = 1'b0;
    mode = ~m;
    wait_out(res, sat, lat);
  endtask

  task automatic wr_coef(input logic [1:0] b, input logic [2:0] a, input logic signed [15:0] d);
    coef_we = 1'b1; coef_bank = b; coef_addr = a; coef_data = d;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int res, sat, lat;
    int a0, a1, o0, nacc, run, maxrun, nout;
    int exp_t1 [10] = '{6, 13, 19, 25, 31, 38, 44, 50, 50, 50};
    int exp_t2 [16] = '{6, 0, 6, 0, 6, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int exp_t3 [16] = '{32766, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
                        32767, 32767, 32767, -4, -32768, -32768, -32768, -32768};
    int sat_t3 [16] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};

    do_reset();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_coef_err", int'(coef_err), 0);

    // T1: moving-average step response from reset coefficients
    for (int i = 0; i < 10; i++) begin
      send(16'sd50, 2'd3, 1'b0, 2'd0, 3'd0, 16'sd0, res, sat, lat);
      check($sformatf("t1_out%0d", i), res, exp_t1[i]);
      check($sformatf("t1_sat%0d", i), sat, 0);
      if (i == 0) check("t1_latency", lat, 9);
    end

    // T2: alternating input from a cleared delay line
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send((i % 2 == 0) ? 16'sd50 : -16'sd50, 2'd3, 1'b0, 2'd0, 3'd0, 16'sd0, res, sat, lat);
      check($sformatf("t2_out%0d", i), res, exp_t2[i]);
      check($sformatf("t2_sat%0d", i), sat, 0);
    end

    // T4: in_valid held high
    @(negedge clk);
    a0 = -1; a1 = -1; o0 = -1; nacc = 0; run = 0; maxrun = 0;
    in_valid = 1'b1; in_data = 16'sd50; mode = 2'd3;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (in_ready && in_valid) begin
        nacc++;
        if (a0 < 0) a0 = c;
        else if (a1 < 0) a1 = c;
      end
      if (out_valid) begin
        run++;
        if (o0 < 0 && a0 >= 0 && c > a0) o0 = c;
      end else run = 0;
      if (run > maxrun) maxrun = run;
    end
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("t4_accepts", nacc, 4);
    check("t4_spacing", a1 - a0, 10);
    check("t4_latency", o0 - a0, 10);
    check("t4_pulse_width", maxrun, 1);

    // T3: saturation with a full-scale bank 0
    do_reset();
    for (int k = 0; k < 8; k++) wr_coef(2'd0, 3'(k), 16'sd32767);
    for (int i = 0; i < 16; i++) begin
      send((i < 8) ? 16'sd32767 : -16'sd32768, 2'd0, 1'b0, 2'd0, 3'd0, 16'sd0, res, sat, lat);
      check($sformatf("t3_out%0d", i), res, exp_t3[i]);
      check($sformatf("t3_sat%0d", i), sat, sat_t3[i]);
    end

    // T5: coefficient path, dropped write during MAC, write coincident with accept
    wr_coef(2'd1, 3'd0, 16'sd16384);
    check("t5_idle_err", int'(coef_err), 0);
    send(16'sd100, 2'd1, 1'b0, 2'd0, 3'd0, 16'sd0, res, sat, lat);
    check("t5_out_a", res, 50);
    in_valid = 1'b1; in_data = 16'sd200; mode = 2'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    coef_we = 1'b1; coef_bank = 2'd1; coef_addr = 3'd0; coef_data = 16'sd32767;
    @(posedge clk);
    #1 coef_we = 1'b0;
    @(negedge clk);
    check("t5_coef_err", int'(coef_err), 1);
    @(negedge clk);
    check("t5_coef_err_pulse", int'(coef_err), 0);
    wait_out(res, sat, lat);
    check("t5_out_b", res, 100);
    send(16'sd300, 2'd1, 1'b0, 2'd0, 3'd0, 16'sd0, res, sat, lat);
    check("t5_out_c", res, 150);
    send(16'sd100, 2'd1, 1'b1, 2'd1, 3'd0, 16'sd32767, res, sat, lat);
    check("t5_out_same_cycle", res, 100);
    check("t5_same_cycle_err", int'(coef_err), 0);

    // T6: asynchronous reset in the middle of a MAC run
    in_valid = 1'b1; in_data = 16'sd1000; mode = 2'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("t6_busy", int'(in_ready), 0);
    rst = 1'b1;
    #1;
    check("t6_rst_in_ready", int'(in_ready), 1);
    check("t6_rst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    nout = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) nout++;
    end
    check("t6_no_output", nout, 0);
    send(16'sd50, 2'd3, 1'b0, 2'd0, 3'd0, 16'sd0, res, sat, lat);
    check("t6_out_after_rst", res, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
